mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing the single 256-bit off-chip memory port between the instruction cache and the data cache of the pipelined CPU. It sits between the two caches and the top-level `mem_*` pins. It latches one line request at a time and holds it stable until the memory acknowledges. Ties are resolved round-robin, and a watchdog aborts transactions the memory never acknowledges.

## Interface
Parameters:
- `ADDR_W`, 32: line address width.
- `LINE_W`, 256: cache-line data width.
- `TIMEOUT`, 64: maximum cycles in a grant state without `mem_ack_i`; minimum 2.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `ic_enable_i` in 1: icache request; held high until `ic_ack_o`.
- `ic_write_i` in 1: icache write flag; always 0 in normal use, honoured anyway.
- `ic_addr_i` in `ADDR_W`: icache line address.
- `ic_data_i` in `LINE_W`: icache write data.
- `ic_ack_o` out 1: one-cycle completion pulse to icache.
- `dc_enable_i`, `dc_write_i`, `dc_addr_i`, `dc_data_i`, `dc_ack_o`: same as the icache signals, for the dcache.
- `rd_data_o` out `LINE_W`: read line; valid while either ack is high.
- `mem_enable_o` out 1: memory request.
- `mem_write_o` out 1: memory write flag.
- `mem_addr_o` out `ADDR_W`: memory address.
- `mem_data_o` out `LINE_W`: memory write data.
- `mem_data_i` in `LINE_W`: memory read data.
- `mem_ack_i` in 1: memory completion pulse.
- `err_o` out 1: sticky timeout flag.

## Operation
- FSM states: `IDLE`, `GNT_I`, `GNT_D`. Reset state is `IDLE`.
- In `IDLE`, at a clock edge:
  - Only `dc_enable_i` high: go to `GNT_D`.
  - Only `ic_enable_i` high: go to `GNT_I`.
  - Both high: grant the side selected by `prio_d_r`. If `prio_d_r`=1, go to `GNT_D`; otherwise go to `GNT_I`.
  - Neither high: stay in `IDLE`.
- On a grant, latch the winner's `write`, `addr` and `data` into `req_*_r`. The `mem_*` outputs are driven only from these registers. Requester inputs changing mid-transaction have no effect.
- `mem_enable_o` is 1 exactly while in `GNT_I` or `GNT_D`.
- In `GNT_X`, if `mem_ack_i`=1:
  - `X_ack_o` is 1 in that cycle (combinational).
  - `rd_data_o` equals `mem_data_i`.
  - Next state is `IDLE`.
  - `prio_d_r` updates: it becomes 0 after serving D and 1 after serving I.
- `mem_ack_i` in `IDLE` is ignored. It produces no ack and no error.
- Timeout counter `wait_r` (width `$clog2(TIMEOUT)`):
  - Clears on entering a grant state and increments each grant cycle without ack.
  - If `wait_r`=`TIMEOUT-1` with no ack, set `err_o`, return to `IDLE` and pulse no ack. `prio_d_r` is unchanged.
  - A requester whose `enable_i` is still high is re-arbitrated normally, which gives an implicit retry.
- `err_o` clears only on reset.
- `rd_data_o` is 0 when neither ack is high.

## Timing
- Reset values:
  - State `IDLE`.
  - `prio_d_r`=1.
  - `req_*_r`=0, `wait_r`=0, `err_o`=0.
  - All `mem_*` outputs 0 and both acks 0.
- Grant latency: a request high before edge N makes `mem_enable_o` 1 from cycle N+1.
- Completion:
  - Ack in cycle M: requester ack in cycle M, `mem_enable_o`=0 in cycle M+1.
  - The earliest next grant takes effect in cycle M+2. There is always at least one idle cycle between memory transactions.
- Requester rule: deassert `enable` in the cycle after its ack. An enable still high at the M+1 edge is treated as a new request.
- Both requests held continuously: grants alternate D, I, D, I after reset.
- Reset asserted mid-transaction: immediately `IDLE` with outputs at reset values. A late `mem_ack_i` is ignored.

## Structure
- Shared package `mem_pkg`: state encoding `arb_state_t` (2 bits: `IDLE`=0, `GNT_I`=1, `GNT_D`=2), `LINE_W` and `ADDR_W` defaults.
- One natural sub-module, `arb_rr2`: a two-way round-robin picker holding `prio_d_r`. Inputs are both request bits and an update strobe; outputs are the grant-D and grant-I bits.
- The FSM, request latch, timeout counter and output muxing live in the top module.

## Test plan
- Single dcache read: `dc_enable_i`=1, `dc_addr_i`=0x0000_0400, memory acks 10 cycles after enable. Expect `mem_addr_o`=0x400 from N+1, `dc_ack_o` in the same cycle as `mem_ack_i`, `rd_data_o`=`mem_data_i`, `mem_enable_o`=0 the next cycle.
- Simultaneous requests after reset: icache at 0x100, dcache at 0x200, both held. Expect the dcache granted first (0x200), the icache next (0x100) after one idle cycle, then alternation.
- Request stability: change `dc_addr_i` to 0x999 mid-grant. Expect `mem_addr_o` to stay at the latched 0x200 until ack.
- Write path: dcache `dc_write_i`=1, data 256'hA5…A5. Expect `mem_write_o`=1 and `mem_data_o`=A5…A5 for the whole grant, and `ic_ack_o` never high.
- Timeout with `TIMEOUT`=8 and memory never acking: expect `err_o`=1 after 8 grant cycles, `IDLE` for 1 cycle, then a re-grant of the same held request. `err_o` stays high until `rst_i`=0.
- Reset mid-grant: assert `rst_i` low in cycle 3 of a grant. Expect all outputs 0 immediately, and a spurious `mem_ack_i` after reset release produces no ack.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the cache-to-memory arbiter: state encoding and
// default bus widths.
package mem_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int LINE_W_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and off-chip memory signals seen by the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's.
interface mem_arbiter_if import mem_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int LINE_W = LINE_W_DEFAULT
) ();

    logic              ic_enable_i;
    logic              ic_write_i;
    logic [ADDR_W-1:0] ic_addr_i;
    logic [LINE_W-1:0] ic_data_i;
    logic              ic_ack_o;

    logic              dc_enable_i;
    logic              dc_write_i;
    logic [ADDR_W-1:0] dc_addr_i;
    logic [LINE_W-1:0] dc_data_i;
    logic              dc_ack_o;

    logic [LINE_W-1:0] rd_data_o;

    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;

    logic              err_o;

    modport slave (
        input  ic_enable_i, ic_write_i, ic_addr_i, ic_data_i,
        output ic_ack_o,
        input  dc_enable_i, dc_write_i, dc_addr_i, dc_data_i,
        output dc_ack_o,
        output rd_data_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i,
        output err_o
    );

    modport master (
        output ic_enable_i, ic_write_i, ic_addr_i, ic_data_i,
        input  ic_ack_o,
        output dc_enable_i, dc_write_i, dc_addr_i, dc_data_i,
        input  dc_ack_o,
        input  rd_data_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i,
        input  err_o
    );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin picker. prio_d_r names the side that wins a tie and
// flips to the other side whenever a transaction completes.
module arb_rr2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ic_req,
    input  logic dc_req,
    input  logic update,
    input  logic update_d,
    output logic ic_gnt,
    output logic dc_gnt
);

    logic prio_d_r;

    assign dc_gnt = dc_req && (!ic_req || prio_d_r);
    assign ic_gnt = ic_req && (!dc_req || !prio_d_r);

    // update_d says the completed transaction belonged to the dcache, so the
    // icache gets the next tie, and vice versa.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prio_d_r <= 1'b1;
        end else if (update) begin
            prio_d_r <= !update_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the off-chip line port between icache and dcache. One request
// is latched at a time and held on the mem_* pins until acked or timed out.
module mem_arbiter import mem_pkg::*; #(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int LINE_W  = LINE_W_DEFAULT,
    parameter int TIMEOUT = 64
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mem_arbiter_if.slave   bus
);

    localparam int                WAIT_W   = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    arb_state_t        state_r;
    logic              req_write_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic [LINE_W-1:0] req_data_r;
    logic [WAIT_W-1:0] wait_r;
    logic              err_r;

    logic              gnt_i;
    logic              gnt_d;
    logic              in_grant;
    logic              ack_i;
    logic              ack_d;
    logic              served;

    assign in_grant = (state_r == GNT_I) || (state_r == GNT_D);
    assign ack_i    = (state_r == GNT_I) && bus.mem_ack_i;
    assign ack_d    = (state_r == GNT_D) && bus.mem_ack_i;
    assign served   = ack_i || ack_d;

    arb_rr2 u_rr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ic_req   (bus.ic_enable_i),
        .dc_req   (bus.dc_enable_i),
        .update   (served),
        .update_d (ack_d),
        .ic_gnt   (gnt_i),
        .dc_gnt   (gnt_d)
    );

    // A timeout leaves the picker untouched, so a still-held request simply
    // competes again from IDLE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= IDLE;
            req_write_r <= 1'b0;
            req_addr_r  <= '0;
            req_data_r  <= '0;
            wait_r      <= '0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    wait_r <= '0;
                    if (gnt_d) begin
                        state_r     <= GNT_D;
                        req_write_r <= bus.dc_write_i;
                        req_addr_r  <= bus.dc_addr_i;
                        req_data_r  <= bus.dc_data_i;
                    end else if (gnt_i) begin
                        state_r     <= GNT_I;
                        req_write_r <= bus.ic_write_i;
                        req_addr_r  <= bus.ic_addr_i;
                        req_data_r  <= bus.ic_data_i;
                    end
                end
                GNT_I, GNT_D: begin
                    if (bus.mem_ack_i) begin
                        state_r <= IDLE;
                    end else if (wait_r == WAIT_MAX) begin
                        state_r <= IDLE;
                        err_r   <= 1'b1;
                    end else begin
                        wait_r <= wait_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_enable_o = in_grant;
    assign bus.mem_write_o  = req_write_r;
    assign bus.mem_addr_o   = req_addr_r;
    assign bus.mem_data_o   = req_data_r;
    assign bus.ic_ack_o     = ack_i;
    assign bus.dc_ack_o     = ack_d;
    assign bus.rd_data_o    = served ? bus.mem_data_i : '0;
    assign bus.err_o        = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expected transactions,
// a monitor pops and compares them whenever the arbiter acks a cache.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
    mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus2 ();

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(64)) u_dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(8)) u_dut_to (
        .clk_i (clk),
        .rst_i (rst2_n),
        .bus   (bus2)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        logic [LW-1:0] rd;
    } exp_t;

    exp_t          q_i[$];
    exp_t          q_d[$];
    bit            order_q[$];
    logic [LW-1:0] ref_mem  [logic [AW-1:0]];
    logic [LW-1:0] phys_mem [logic [AW-1:0]];

    int n_total = 0;
    int n_pass  = 0;

    int lat_fixed  = -1;
    bit resp_noack = 0;
    bit force_ack  = 0;
    bit rec_order  = 0;

    function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
        logic [LW-1:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = a * 32'h9E37_79B1 + 32'(k);
        return v;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [LW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    task automatic check_output(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Issue one cache request, record what memory must see, wait for its ack.
    task automatic apply_stimulus(input bit is_d, input bit wr, input logic [AW-1:0] addr,
                                  input logic [LW-1:0] data, input bit keep, input bit perturb);
        exp_t e;
        bit   got;
        e.wr   = wr;
        e.addr = addr;
        e.data = data;
        e.rd   = wr ? '0 : ref_read(addr);
        if (wr) ref_mem[addr] = data;
        if (is_d) begin
            q_d.push_back(e);
            bus.dc_enable_i = 1'b1;
            bus.dc_write_i  = wr;
            bus.dc_addr_i   = addr;
            bus.dc_data_i   = data;
        end else begin
            q_i.push_back(e);
            bus.ic_enable_i = 1'b1;
            bus.ic_write_i  = wr;
            bus.ic_addr_i   = addr;
            bus.ic_data_i   = data;
        end
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            got = is_d ? bus.dc_ack_o : bus.ic_ack_o;
            if (perturb && c == 3 && !got) begin
                bus.dc_addr_i  = 32'h999;
                bus.dc_data_i  = ~data;
                bus.dc_write_i = ~wr;
            end
        end
        if (!got) begin
            n_total++;
            $display("[TB] FAIL ack_wait: side_d=%0d saw no ack in 400 cycles, expected an ack", is_d);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            if (is_d) bus.dc_enable_i = 1'b0;
            else      bus.ic_enable_i = 1'b0;
        end
    endtask

    // Memory model: acks after a chosen latency and serves lines from phys_mem.
    initial begin : responder
        int busy;
        busy = -1;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack_i  = 1'b0;
            bus.mem_data_i = '0;
            if (force_ack) begin
                bus.mem_ack_i  = 1'b1;
                bus.mem_data_i = rand_line();
            end else if (!rst_n) begin
                busy = -1;
            end else if (bus.mem_enable_o && !resp_noack) begin
                if (busy < 0) busy = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 12));
                if (busy == 0) begin
                    bus.mem_ack_i = 1'b1;
                    if (bus.mem_write_o) begin
                        phys_mem[bus.mem_addr_o] = bus.mem_data_o;
                        bus.mem_data_i = rand_line();
                    end else begin
                        bus.mem_data_i = phys_mem.exists(bus.mem_addr_o) ?
                                         phys_mem[bus.mem_addr_o] : init_line(bus.mem_addr_o);
                    end
                    busy = -1;
                end else begin
                    busy--;
                end
            end else begin
                busy = -1;
            end
        end
    end

    // Monitor: per-cycle protocol rules plus scoreboard pop on every ack.
    initial begin : monitor
        bit            prev_en, prev_ack, idle_both, grant_both, last_d, any_ack, is_d;
        logic [AW-1:0] g_addr;
        logic          g_wr;
        logic [LW-1:0] g_data;
        exp_t          e;
        prev_en = 0; prev_ack = 0; idle_both = 0; grant_both = 0; last_d = 0;
        g_addr = '0; g_wr = 1'b0; g_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en = 0; prev_ack = 0; idle_both = 0; last_d = 0;
            end else begin
                any_ack = bus.ic_ack_o || bus.dc_ack_o;
                check_output("ack_gating", LW'(any_ack), LW'(bus.mem_enable_o && bus.mem_ack_i));
                check_output("rd_data", bus.rd_data_o, any_ack ? bus.mem_data_i : '0);
                if (prev_ack) check_output("idle_after_ack", LW'(bus.mem_enable_o), LW'(1'b0));
                if (bus.mem_enable_o && !prev_en) begin
                    grant_both = idle_both;
                    g_addr = bus.mem_addr_o;
                    g_wr   = bus.mem_write_o;
                    g_data = bus.mem_data_o;
                end else if (bus.mem_enable_o) begin
                    check_output("hold_addr", LW'(bus.mem_addr_o), LW'(g_addr));
                    check_output("hold_write", LW'(bus.mem_write_o), LW'(g_wr));
                    check_output("hold_data", bus.mem_data_o, g_data);
                end
                if (!bus.mem_enable_o) idle_both = bus.ic_enable_i && bus.dc_enable_i;
                if (bus.ic_ack_o && bus.dc_ack_o) begin
                    n_total++;
                    $display("[TB] FAIL ack_onehot: both acks high, expected at most one");
                end else if (any_ack) begin
                    is_d = bus.dc_ack_o;
                    if ((is_d ? q_d.size() : q_i.size()) == 0) begin
                        n_total++;
                        $display("[TB] FAIL unexpected_ack: side_d=%0d acked with nothing pending", is_d);
                    end else begin
                        e = is_d ? q_d.pop_front() : q_i.pop_front();
                        check_output("txn_addr", LW'(bus.mem_addr_o), LW'(e.addr));
                        check_output("txn_write", LW'(bus.mem_write_o), LW'(e.wr));
                        if (e.wr) check_output("txn_wdata", bus.mem_data_o, e.data);
                        else      check_output("txn_rdata", bus.rd_data_o, e.rd);
                        if (grant_both) check_output("rr_order", LW'(is_d), LW'(!last_d));
                        last_d = is_d;
                        if (rec_order) order_q.push_back(is_d);
                    end
                end
                prev_en  = bus.mem_enable_o;
                prev_ack = any_ack;
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("[TB] FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin : main
        int cnt;
        bus.ic_enable_i = 0; bus.ic_write_i = 0; bus.ic_addr_i = '0; bus.ic_data_i = '0;
        bus.dc_enable_i = 0; bus.dc_write_i = 0; bus.dc_addr_i = '0; bus.dc_data_i = '0;
        bus2.ic_enable_i = 0; bus2.ic_write_i = 0; bus2.ic_addr_i = '0; bus2.ic_data_i = '0;
        bus2.dc_enable_i = 0; bus2.dc_write_i = 0; bus2.dc_addr_i = '0; bus2.dc_data_i = '0;
        bus2.mem_ack_i = 0; bus2.mem_data_i = '0;
        rst_n = 0; rst2_n = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_enable", LW'(bus.mem_enable_o), '0);
        check_output("rst_write", LW'(bus.mem_write_o), '0);
        check_output("rst_addr", LW'(bus.mem_addr_o), '0);
        check_output("rst_data", bus.mem_data_o, '0);
        check_output("rst_ic_ack", LW'(bus.ic_ack_o), '0);
        check_output("rst_dc_ack", LW'(bus.dc_ack_o), '0);
        check_output("rst_err", LW'(bus.err_o), '0);
        check_output("rst_rd_data", bus.rd_data_o, '0);
        @(posedge clk);
        #1;
        rst_n = 1; rst2_n = 1;

        $display("[TB] both caches held continuously from reset");
        rec_order = 1;
        fork
            begin for (int k = 0; k < 3; k++) apply_stimulus(1, 0, 32'h200, '0, k < 2, 0); end
            begin for (int k = 0; k < 3; k++) apply_stimulus(0, 0, 32'h100, '0, k < 2, 0); end
        join
        rec_order = 0;
        check_output("alt_count", LW'(order_q.size()), LW'(6));
        for (int k = 0; k < order_q.size() && k < 6; k++)
            check_output("alt_order", LW'(order_q[k]), LW'(k % 2 == 0));

        $display("[TB] single dcache read, latency 10");
        lat_fixed = 10;
        repeat (2) @(posedge clk);
        #1;
        fork
            apply_stimulus(1, 0, 32'h400, '0, 0, 0);
            begin
                @(posedge clk);
                @(negedge clk);
                check_output("grant_latency_en", LW'(bus.mem_enable_o), LW'(1'b1));
                check_output("grant_latency_addr", LW'(bus.mem_addr_o), LW'(32'h400));
            end
        join

        $display("[TB] request stability, write path, icache write");
        apply_stimulus(1, 0, 32'h200, '0, 0, 1);
        apply_stimulus(1, 1, 32'h204, {32{8'hA5}}, 0, 0);
        apply_stimulus(1, 0, 32'h204, '0, 0, 0);
        apply_stimulus(0, 1, 32'h104, rand_line(), 0, 0);
        apply_stimulus(0, 0, 32'h104, '0, 0, 0);

        $display("[TB] randomized traffic from both caches");
        lat_fixed = -1;
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    bit kp;
                    kp = (k < 29) && ($urandom_range(0, 2) == 0);
                    apply_stimulus(1, $urandom_range(0, 9) < 3, 32'h200 + $urandom_range(0, 7),
                                   rand_line(), kp, 0);
                    if (!kp) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    bit kp;
                    kp = (k < 29) && ($urandom_range(0, 2) == 0);
                    apply_stimulus(0, $urandom_range(0, 9) < 1, 32'h100 + $urandom_range(0, 7),
                                   rand_line(), kp, 0);
                    if (!kp) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
            end
        join
        check_output("no_err_main", LW'(bus.err_o), '0);
        check_output("queues_drained", LW'(q_i.size() + q_d.size()), '0);

        $display("[TB] timeout with TIMEOUT=8");
        @(posedge clk);
        #1;
        bus2.dc_enable_i = 1;
        bus2.dc_addr_i   = 32'h300;
        for (int c = 0; c < 10 && !bus2.mem_enable_o; c++) @(negedge clk);
        check_output("to_granted", LW'(bus2.mem_enable_o), LW'(1'b1));
        check_output("to_err_before", LW'(bus2.err_o), '0);
        cnt = 0;
        for (int c = 0; c < 40 && bus2.mem_enable_o; c++) begin
            cnt++;
            @(negedge clk);
        end
        check_output("to_grant_cycles", LW'(cnt), LW'(8));
        check_output("to_err_set", LW'(bus2.err_o), LW'(1'b1));
        check_output("to_no_ack", LW'(bus2.ic_ack_o || bus2.dc_ack_o), '0);
        @(negedge clk);
        check_output("to_regrant_en", LW'(bus2.mem_enable_o), LW'(1'b1));
        check_output("to_regrant_addr", LW'(bus2.mem_addr_o), LW'(32'h300));
        @(posedge clk);
        #1;
        bus2.dc_enable_i = 0;
        repeat (20) @(negedge clk);
        check_output("to_err_sticky", LW'(bus2.err_o), LW'(1'b1));
        #1 rst2_n = 0;
        #1;
        check_output("to_err_cleared", LW'(bus2.err_o), '0);
        @(posedge clk);
        #1 rst2_n = 1;

        $display("[TB] reset in the middle of a grant");
        resp_noack = 1;
        @(posedge clk);
        #1;
        bus.dc_enable_i = 1;
        bus.dc_write_i  = 1;
        bus.dc_addr_i   = 32'h208;
        bus.dc_data_i   = rand_line();
        for (int c = 0; c < 10 && !bus.mem_enable_o; c++) @(negedge clk);
        check_output("rstg_granted", LW'(bus.mem_enable_o), LW'(1'b1));
        repeat (2) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check_output("rstg_enable", LW'(bus.mem_enable_o), '0);
        check_output("rstg_write", LW'(bus.mem_write_o), '0);
        check_output("rstg_addr", LW'(bus.mem_addr_o), '0);
        check_output("rstg_data", bus.mem_data_o, '0);
        check_output("rstg_err", LW'(bus.err_o), '0);
        bus.dc_enable_i = 0;
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        force_ack = 1;
        @(negedge clk);
        force_ack = 0;
        check_output("spurious_ic_ack", LW'(bus.ic_ack_o), '0);
        check_output("spurious_dc_ack", LW'(bus.dc_ack_o), '0);
        check_output("spurious_rd_data", bus.rd_data_o, '0);
        @(negedge clk);
        check_output("spurious_err", LW'(bus.err_o), '0);
        check_output("spurious_enable", LW'(bus.mem_enable_o), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
